// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order memory requests and buffers {pc, instr}
// pairs in a circular prefetch queue; a redirect flushes the queue and drops stale responses.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     QUEUE_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_valid,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] slot_pc    [QUEUE_DEPTH];
    logic [ILEN-1:0] slot_instr [QUEUE_DEPTH];
    logic [PW-1:0]   head, fill, issue, drop_cnt;

    logic [PW-1:0]   allocated, unfilled;
    logic [PW:0]     outstanding, credits_used;
    logic            req_fire, pop_fire, rsp_in_branch;

    always_comb begin
        allocated      = issue - head;
        unfilled       = issue - fill;
        outstanding    = {1'b0, unfilled} + {1'b0, drop_cnt};
        credits_used   = {1'b0, allocated} + {1'b0, drop_cnt};
        imem_req_valid = !branch_valid && (credits_used < (PW+1)'(QUEUE_DEPTH));
        imem_req_addr  = fetch_pc;
        out_valid      = !branch_valid && (fill != head);
        out_pc         = slot_pc[head[AW-1:0]];
        out_instr      = slot_instr[head[AW-1:0]];
        req_fire       = imem_req_valid && imem_req_ready;
        pop_fire       = out_valid && out_ready;
        // guard keeps drop_cnt from underflowing on an unsolicited response
        rsp_in_branch  = imem_rsp_valid && (outstanding != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_VECTOR;
            head     <= '0;
            fill     <= '0;
            issue    <= '0;
            drop_cnt <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= '0;
            end
        end else if (branch_valid) begin
            head     <= issue;
            fill     <= issue;
            drop_cnt <= PW'(outstanding - {{PW{1'b0}}, rsp_in_branch});
            fetch_pc <= branch_target & ~XLEN'(3);
        end else begin
            if (req_fire) begin
                slot_pc[issue[AW-1:0]] <= fetch_pc;
                issue                  <= issue + PW'(1);
                fetch_pc               <= fetch_pc + XLEN'(4);
            end
            if (imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - PW'(1);
                end else if (unfilled != '0) begin
                    slot_instr[fill[AW-1:0]] <= imem_rsp_data;
                    fill                     <= fill + PW'(1);
                end
            end
            if (pop_fire) begin
                head <= head + PW'(1);
            end
        end
    end

endmodule
